// File: rtl/lc4_divmod_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : lc4_divmod_seq_if
// Purpose  : Start/busy/valid handshake between the pipeline control unit
//            and the multi-cycle LC4 DIV/MOD sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface lc4_divmod_seq_if;
    logic        i_start;
    logic        i_op_mod;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic        i_flush;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_result;

    // Pipeline side: issues operations, consumes results
    modport master (
        output i_start, i_op_mod, i_dividend, i_divisor, i_flush,
        input  o_busy, o_valid, o_result
    );

    // Sequencer side
    modport slave (
        input  i_start, i_op_mod, i_dividend, i_divisor, i_flush,
        output o_busy, o_valid, o_result
    );
endinterface
`default_nettype wire

// File: rtl/lc4_divmod_seq.sv
`default_nettype none
// ============================================================================
// Module   : lc4_divmod_seq
// Purpose  : Iterative unsigned 16-bit restoring divider for LC4 DIV/MOD.
//            Retires BITS_PER_CYCLE quotient bits per RUN cycle; DONE lasts
//            one cycle and carries the result.
// Revision : 1.0 - initial release
// ============================================================================
module lc4_divmod_seq #(
    parameter int BITS_PER_CYCLE = 1    // legal: 1, 2, 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lc4_divmod_seq_if.slave      bus
);

    localparam int         ITERS = 16 / BITS_PER_CYCLE;
    localparam logic [4:0] C_N   = 5'(ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dq_q, dq_d;        // dividend shifting out, quotient shifting in
    logic [15:0] div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [15:0] result_q, result_d;

    logic [15:0] rem_step;
    logic [15:0] dq_step;
    logic [16:0] rem17;
    logic [16:0] diff17;

    // BITS_PER_CYCLE chained restoring steps from the current remainder/quotient
    always_comb begin
        rem_step = rem_q;
        dq_step  = dq_q;
        rem17    = '0;
        diff17   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem17   = {rem_step, dq_step[15]};
            dq_step = {dq_step[14:0], 1'b0};
            diff17  = rem17 - {1'b0, div_q};
            if (rem17 >= {1'b0, div_q}) begin
                rem_step   = diff17[15:0];
                dq_step[0] = 1'b1;
            end else begin
                rem_step   = rem17[15:0];
            end
        end
    end

    // Next-state and datapath control; flush beats start, start in RUN is ignored
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            S_RUN: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    dq_d  = dq_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = S_DONE;
                        result_d = op_q ? rem_step : dq_step;
                    end
                end
            end
            default: begin  // S_IDLE, S_DONE
                state_d = S_IDLE;
                if (!bus.i_flush && bus.i_start) begin
                    rem_d = 16'h0000;
                    dq_d  = bus.i_dividend;
                    div_d = bus.i_divisor;
                    op_d  = bus.i_op_mod;
                    cnt_d = C_N;
                    if (bus.i_divisor == 16'h0000) begin
                        // Divide by zero returns 0 for both DIV and MOD
                        state_d  = S_DONE;
                        result_d = 16'h0000;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            dq_q     <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.o_busy   = (state_q == S_RUN);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_lc4_divmod_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_divmod_seq
// Purpose  : Bench for lc4_divmod_seq with BITS_PER_CYCLE = 1, 2 and 4
//            instances sharing one stimulus stream, each tracked by an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_divmod_seq;

    logic        clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        s_start = 1'b0;
    logic        s_op = 1'b0;
    logic [15:0] s_a = 16'h0;
    logic [15:0] s_b = 16'h0;
    logic        s_flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc4_divmod_seq_if if0 ();
    lc4_divmod_seq_if if1 ();
    lc4_divmod_seq_if if2 ();

    assign if0.i_start = s_start;  assign if0.i_op_mod = s_op;  assign if0.i_flush = s_flush;
    assign if0.i_dividend = s_a;   assign if0.i_divisor = s_b;
    assign if1.i_start = s_start;  assign if1.i_op_mod = s_op;  assign if1.i_flush = s_flush;
    assign if1.i_dividend = s_a;   assign if1.i_divisor = s_b;
    assign if2.i_start = s_start;  assign if2.i_op_mod = s_op;  assign if2.i_flush = s_flush;
    assign if2.i_dividend = s_a;   assign if2.i_divisor = s_b;

    lc4_divmod_seq #(.BITS_PER_CYCLE(1)) u_dut0 (.clk(clk), .rst(s_rst), .bus(if0.slave));
    lc4_divmod_seq #(.BITS_PER_CYCLE(2)) u_dut1 (.clk(clk), .rst(s_rst), .bus(if1.slave));
    lc4_divmod_seq #(.BITS_PER_CYCLE(4)) u_dut2 (.clk(clk), .rst(s_rst), .bus(if2.slave));

    logic [2:0]  v_busy, v_valid;
    logic [15:0] v_res [3];
    assign v_busy  = {if2.o_busy,  if1.o_busy,  if0.o_busy};
    assign v_valid = {if2.o_valid, if1.o_valid, if0.o_valid};
    assign v_res[0] = if0.o_result;
    assign v_res[1] = if1.o_result;
    assign v_res[2] = if2.o_result;

    // Reference model: phase 0 idle, 1 computing, 2 result presented.
    // Result is plain a/b or a%b; latency is 16/BPC computing cycles.
    int m_ph   [3] = '{0, 0, 0};
    int m_left [3] = '{0, 0, 0};
    int m_pend [3] = '{0, 0, 0};
    int m_res  [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (s_rst) begin
                m_ph[k]  <= 0;
                m_res[k] <= 0;
            end else if (m_ph[k] == 1) begin
                if (s_flush) m_ph[k] <= 0;
                else if (m_left[k] == 1) begin
                    m_ph[k]  <= 2;
                    m_res[k] <= m_pend[k];
                end else m_left[k] <= m_left[k] - 1;
            end else begin
                if (s_flush) m_ph[k] <= 0;
                else if (s_start) begin
                    if (s_b == 16'h0) begin
                        m_ph[k]  <= 2;
                        m_res[k] <= 0;
                    end else begin
                        m_ph[k]   <= 1;
                        m_left[k] <= 16 >> k;
                        m_pend[k] <= s_op ? (int'(s_a) % int'(s_b)) : (int'(s_a) / int'(s_b));
                    end
                end else m_ph[k] <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three instances against the model
    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_busy[%0d]", k),  32'(v_busy[k]),  32'(m_ph[k] == 1));
            chk($sformatf("model_valid[%0d]", k), 32'(v_valid[k]), 32'(m_ph[k] == 2));
            chk($sformatf("model_result[%0d]", k), 32'(v_res[k]),  32'(m_res[k]));
        end
    endtask

    // Compare mid-cycle, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h0001;
            3:       return 16'($urandom % 16);
            default: return 16'($urandom);
        endcase
    endfunction

    // Issue one operation on instance 0 and check latency, busy length and result
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic [15:0] exp, input int exp_lat, input int exp_busy,
                          input bit mid, input string nm);
        int lat;
        int nb;
        bit got;
        s_a = a; s_b = b; s_op = op; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        lat = 0; nb = 0; got = 1'b0;
        while (!got && lat < 40) begin
            lat++;
            if (v_busy[0])  nb++;
            if (v_valid[0]) got = 1'b1;
            if (!got) begin
                if (mid && lat == 5) begin
                    s_a = 16'd9; s_b = 16'd2; s_op = 1'b0; s_start = 1'b1;
                end else begin
                    s_a = 16'($urandom); s_b = 16'($urandom); s_op = 1'($urandom); s_start = 1'b0;
                end
                tick();
            end
        end
        s_start = 1'b0;
        chk({nm, "_latency"},     got ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({nm, "_busy_cycles"}, 32'(nb),                        32'(exp_busy));
        chk({nm, "_result"},      32'(v_res[0]),                  32'(exp));
        chk({nm, "_model"},       32'(m_res[0]),                  32'(exp));
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy",   32'(v_busy[k]),  32'd0);
            chk("reset_valid",  32'(v_valid[k]), 32'd0);
            chk("reset_result", 32'(v_res[k]),   32'd0);
        end
        s_rst = 1'b0;
        tick();

        run_op(16'd100,   16'd7,      1'b0, 16'd14,     17, 16, 1'b0, "div_100_7");
        run_op(16'd100,   16'd7,      1'b1, 16'd2,      17, 16, 1'b0, "mod_100_7");
        run_op(16'hFFFF,  16'd1,      1'b0, 16'hFFFF,   17, 16, 1'b0, "div_ffff_1");
        run_op(16'hFFFF,  16'd1,      1'b1, 16'd0,      17, 16, 1'b0, "mod_ffff_1");
        run_op(16'd5,     16'hFFFF,   1'b0, 16'd0,      17, 16, 1'b0, "div_5_ffff");
        run_op(16'd5,     16'hFFFF,   1'b1, 16'd5,      17, 16, 1'b0, "mod_5_ffff");
        run_op(16'd0,     16'd3,      1'b0, 16'd0,      17, 16, 1'b0, "div_0_3");
        run_op(16'd1234,  16'd0,      1'b0, 16'd0,       1,  0, 1'b0, "div_by_zero");
        run_op(16'd1234,  16'd0,      1'b1, 16'd0,       1,  0, 1'b0, "mod_by_zero");
        run_op(16'd50,    16'd6,      1'b0, 16'd8,      17, 16, 1'b1, "div_50_6_midstart");
        run_op(16'd9,     16'd2,      1'b1, 16'd1,      17, 16, 1'b0, "mod_9_2_b2b");

        // Flush in the fifth RUN cycle
        s_a = 16'd100; s_b = 16'd7; s_op = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (4) tick();
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        chk("flush_busy",   32'(v_busy[0]),  32'd0);
        chk("flush_valid",  32'(v_valid[0]), 32'd0);
        chk("flush_result", 32'(v_res[0]),   32'd1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (v_valid[0]) seen = 1'b1;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);

        // Reset in the eighth RUN cycle
        s_a = 16'd100; s_b = 16'd7; s_op = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (7) tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_busy",   32'(v_busy[k]),  32'd0);
            chk("midrst_valid",  32'(v_valid[k]), 32'd0);
            chk("midrst_result", 32'(v_res[k]),   32'd0);
        end
        run_op(16'd20, 16'd3, 1'b0, 16'd6, 17, 16, 1'b0, "div_20_3_after_rst");

        // Random traffic on all three widths
        repeat (3000) begin
            s_start = ($urandom % 3) == 0;
            s_flush = ($urandom % 20) == 0;
            s_rst   = ($urandom % 300) == 0;
            s_op    = 1'($urandom);
            s_a     = pick();
            s_b     = pick();
            tick();
        end
        s_start = 1'b0; s_flush = 1'b0; s_rst = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc4_divmod_seq.md
Name: lc4_divmod_seq

Overview:
- Multi-cycle sequencer that executes the LC4 DIV and MOD operations iteratively, replacing the single-cycle combinational divider path of the ALU.
- Runs an unsigned restoring-division datapath under FSM control, with start/busy/valid handshake toward the pipeline control unit.
- The pipeline holds the DIV/MOD instruction in execute while o_busy is high, then takes o_result on the cycle o_valid pulses.

Parameters:
- BITS_PER_CYCLE, default 1, quotient bits retired per RUN cycle. Legal values are 1, 2, 4. Iteration count N = 16 / BITS_PER_CYCLE.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_start  input  1  request a new operation; sampled only when the FSM is in IDLE or DONE
- i_op_mod  input  1  0 = DIV (return quotient), 1 = MOD (return remainder); captured with i_start
- i_dividend  input  16  unsigned dividend (rs); captured with i_start
- i_divisor  input  16  unsigned divisor (rt); captured with i_start
- i_flush  input  1  abort the in-flight operation (branch mispredict or squash)
- o_busy  output  1  high in RUN, and in the cycle a start is accepted is NOT yet high (registered)
- o_valid  output  1  single-cycle pulse; o_result is valid for the requested op
- o_result  output  16  quotient or remainder; holds its value until the next accepted start

Behaviour:
- Reset (rst=1 at an edge):
  - state <= IDLE.
  - o_busy=0, o_valid=0, o_result=16'h0000.
  - Internal remainder, quotient, counter, op and divisor registers all cleared.
  - Reset has priority over i_flush and i_start.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating.
  - DONE: o_valid=1 for exactly this cycle.
- Start acceptance, i_start=1 in IDLE or DONE:
  - Capture the operands and op; clear the remainder.
  - Load counter = N.
  - If divisor != 0, go to RUN. If divisor == 0, go directly to DONE with result 0.
  - i_start while in RUN is ignored. It is neither queued nor errored.
- Each RUN edge performs BITS_PER_CYCLE restoring steps. One step is:
  - rem17 = {rem[15:0], dq[15]}; dq <<= 1.
  - If rem17 >= {1'b0, divisor}: rem = rem17 - divisor and set dq[0]=1. Otherwise rem = rem17[15:0].
  - Then decrement the counter.
- RUN to DONE when the counter reaches 0 at that edge.
  - In DONE, o_result = dq when op=DIV, rem when op=MOD. It is registered on the DONE entry edge.
- DONE to IDLE unless a start is accepted in the DONE cycle. A start in DONE gives back-to-back operation with no idle bubble.
- Latency, measured from the start cycle T:
  - o_valid is high in cycle T+N+1 (T+17 with BPC=1, T+5 with BPC=4).
  - With divisor 0, o_valid is high in cycle T+1.
- o_busy is 1 exactly while state==RUN.
- Flush:
  - i_flush=1 at an edge in RUN or DONE forces state to IDLE and o_valid to 0 on the next cycle.
  - o_result keeps its prior value.
  - Flush and start together in IDLE/DONE: flush wins, the start is dropped.
- Arithmetic is unsigned 16-bit throughout. No signed handling. 0xFFFF is 65535.
- Divide-by-zero rule: DIV and MOD both return 0.
- Operand inputs are don't-care outside the start cycle. Changing them mid-RUN must not affect the result.

Test Plan:
- Basic DIV and MOD: 100 / 7 with i_op_mod=0 gives o_result=14; with i_op_mod=1 gives 2. With BPC=1, o_valid pulses exactly 17 cycles after start, and o_busy is high for 16 cycles.
- Unsigned edges:
  - 0xFFFF / 1 gives 0xFFFF; 0xFFFF mod 1 gives 0.
  - 5 / 0xFFFF gives 0; 5 mod 0xFFFF gives 5.
  - 0 / 3 gives 0.
- Divide by zero: 1234 / 0 gives 0 and 1234 mod 0 gives 0, each with o_valid at T+1 and o_busy never asserted.
- Back-to-back and ignored start:
  - Start 50/6 DIV, and assert i_start with 9/2 mid-RUN; the mid-RUN start is ignored and the result is 8.
  - Then start 9/2 MOD in the DONE cycle; the result is 1, with o_valid at T+17 from the DONE cycle.
- Flush and reset mid-operation:
  - Flush at cycle 5 of RUN: no o_valid, o_busy drops the next cycle, o_result keeps its previous value.
  - rst at cycle 8 of RUN: all outputs 0 the next cycle.
  - A new start 20/3 afterwards gives 6.
- Parameter sweep: BPC=2 and BPC=4 with random operands (including the 0 and 0xFFFF extremes) match the golden model q=a/b, r=a%b (0 when b=0), with latencies 9 and 5.
